// File: rtl/matmul_dispatcher.sv
// Matmul command queue and job sequencer for the systolic wrapper.
// Also owns the shared memory port (host vs wrapper mux with read drain).
module matmul_dispatcher #(
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DATA_WIDTH     = 16,
    parameter int BANKING_FACTOR = 1,
    parameter int MEM_LATENCY    = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]             cmd_addr_w,
    input  logic [ADDRESS_WIDTH-1:0]             cmd_addr_x,
    input  logic [ADDRESS_WIDTH-1:0]             cmd_addr_out,
    input  logic [TAG_WIDTH-1:0]                 cmd_tag,
    output logic                                 cpl_valid,
    input  logic                                 cpl_ready,
    output logic [TAG_WIDTH-1:0]                 cpl_tag,
    output logic                                 cpl_error,
    output logic                                 sa_start,
    input  logic                                 sa_done,
    output logic [ADDRESS_WIDTH-1:0]             sa_base_addr_w,
    output logic [ADDRESS_WIDTH-1:0]             sa_base_addr_x,
    output logic [ADDRESS_WIDTH-1:0]             sa_base_addr_out,
    input  logic [ADDRESS_WIDTH-1:0]             sa_mem_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] sa_mem_req_data,
    input  logic                                 sa_mem_read_en,
    input  logic                                 sa_mem_write_en,
    input  logic [ADDRESS_WIDTH-1:0]             host_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_req_data,
    input  logic                                 host_read_en,
    input  logic                                 host_write_en,
    output logic                                 host_gnt,
    output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
    output logic                                 mem_read_en,
    output logic                                 mem_write_en,
    output logic                                 busy,
    output logic [$clog2(QUEUE_DEPTH):0]         queue_count
);

    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int DRW = $clog2(MEM_LATENCY + 1) + 1;

    localparam logic [PW:0]     QD_L   = (PW + 1)'(QUEUE_DEPTH);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DRW-1:0]  DR_L   = DRW'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_CPL
    } state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] w;
        logic [ADDRESS_WIDTH-1:0] x;
        logic [ADDRESS_WIDTH-1:0] o;
        logic [TAG_WIDTH-1:0]     tag;
    } cmd_t;

    state_t               state;
    cmd_t                 fifo [QUEUE_DEPTH];
    cmd_t                 head;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic [TW-1:0]        timer;
    logic [DRW-1:0]       drain_cnt;
    logic [TAG_WIDTH-1:0] job_tag;
    logic                 push;
    logic                 pop;
    logic                 host_fwd;

    assign cmd_ready   = (count < QD_L);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == S_ISSUE);
    assign head        = fifo[rd_ptr];
    assign queue_count = count;
    assign busy        = (state != S_IDLE);
    assign host_fwd    = host_gnt && (host_read_en || host_write_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo[wr_ptr] <= {cmd_addr_w, cmd_addr_x,
                                 cmd_addr_out, cmd_tag};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Hold off the wrapper until forwarded host accesses have landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (host_fwd) begin
            drain_cnt <= DR_L;
        end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            sa_start         <= 1'b0;
            sa_base_addr_w   <= '0;
            sa_base_addr_x   <= '0;
            sa_base_addr_out <= '0;
            job_tag          <= '0;
            timer            <= '0;
            cpl_valid        <= 1'b0;
            cpl_tag          <= '0;
            cpl_error        <= 1'b0;
        end else begin
            sa_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (count != '0 && drain_cnt == '0) begin
                        state            <= S_ISSUE;
                        sa_start         <= 1'b1;
                        sa_base_addr_w   <= head.w;
                        sa_base_addr_x   <= head.x;
                        sa_base_addr_out <= head.o;
                        job_tag          <= head.tag;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (sa_done) begin
                        state     <= S_CPL;
                        cpl_valid <= 1'b1;
                        cpl_tag   <= job_tag;
                        cpl_error <= 1'b0;
                    end else if (timer == T_LAST) begin
                        state     <= S_CPL;
                        cpl_valid <= 1'b1;
                        cpl_tag   <= job_tag;
                        cpl_error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CPL: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        host_gnt     = (state == S_IDLE) && (count == '0);
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (state != S_IDLE) begin
            mem_req_addr = sa_mem_req_addr;
            mem_req_data = sa_mem_req_data;
            mem_read_en  = sa_mem_read_en;
            mem_write_en = sa_mem_write_en;
        end else if (host_gnt) begin
            mem_req_addr = host_req_addr;
            mem_req_data = host_req_data;
            mem_read_en  = host_read_en;
            mem_write_en = host_write_en;
        end
    end

endmodule

// File: tb/tb_matmul_dispatcher.sv
// Scenario bench for matmul_dispatcher with a scoreboard-based
// random traffic test.
module tb_matmul_dispatcher;

    localparam int AW  = 13;
    localparam int DW  = 16;
    localparam int BF  = 1;
    localparam int ML  = 2;
    localparam int QD  = 4;
    localparam int TGW = 4;
    localparam int TO  = 64;
    localparam int MW  = BF * DW;
    localparam int QCW = $clog2(QD) + 1;

    typedef struct {
        logic [AW-1:0]  w;
        logic [AW-1:0]  x;
        logic [AW-1:0]  o;
        logic [TGW-1:0] tag;
    } job_t;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr_w;
    logic [AW-1:0]  cmd_addr_x;
    logic [AW-1:0]  cmd_addr_out;
    logic [TGW-1:0] cmd_tag;
    logic           cpl_valid;
    logic           cpl_ready;
    logic [TGW-1:0] cpl_tag;
    logic           cpl_error;
    logic           sa_start;
    logic           sa_done;
    logic [AW-1:0]  sa_base_addr_w;
    logic [AW-1:0]  sa_base_addr_x;
    logic [AW-1:0]  sa_base_addr_out;
    logic [AW-1:0]  sa_mem_req_addr;
    logic [MW-1:0]  sa_mem_req_data;
    logic           sa_mem_read_en;
    logic           sa_mem_write_en;
    logic [AW-1:0]  host_req_addr;
    logic [MW-1:0]  host_req_data;
    logic           host_read_en;
    logic           host_write_en;
    logic           host_gnt;
    logic [AW-1:0]  mem_req_addr;
    logic [MW-1:0]  mem_req_data;
    logic           mem_read_en;
    logic           mem_write_en;
    logic           busy;
    logic [QCW-1:0] queue_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    matmul_dispatcher #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .BANKING_FACTOR(BF),
        .MEM_LATENCY   (ML),
        .QUEUE_DEPTH   (QD),
        .TAG_WIDTH     (TGW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr_w      (cmd_addr_w),
        .cmd_addr_x      (cmd_addr_x),
        .cmd_addr_out    (cmd_addr_out),
        .cmd_tag         (cmd_tag),
        .cpl_valid       (cpl_valid),
        .cpl_ready       (cpl_ready),
        .cpl_tag         (cpl_tag),
        .cpl_error       (cpl_error),
        .sa_start        (sa_start),
        .sa_done         (sa_done),
        .sa_base_addr_w  (sa_base_addr_w),
        .sa_base_addr_x  (sa_base_addr_x),
        .sa_base_addr_out(sa_base_addr_out),
        .sa_mem_req_addr (sa_mem_req_addr),
        .sa_mem_req_data (sa_mem_req_data),
        .sa_mem_read_en  (sa_mem_read_en),
        .sa_mem_write_en (sa_mem_write_en),
        .host_req_addr   (host_req_addr),
        .host_req_data   (host_req_data),
        .host_read_en    (host_read_en),
        .host_write_en   (host_write_en),
        .host_gnt        (host_gnt),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .busy            (busy),
        .queue_count     (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        cmd_valid       = 1'b0;
        cmd_addr_w      = '0;
        cmd_addr_x      = '0;
        cmd_addr_out    = '0;
        cmd_tag         = '0;
        cpl_ready       = 1'b0;
        sa_done         = 1'b0;
        sa_mem_req_addr = '0;
        sa_mem_req_data = '0;
        sa_mem_read_en  = 1'b0;
        sa_mem_write_en = 1'b0;
        host_req_addr   = '0;
        host_req_data   = '0;
        host_read_en    = 1'b0;
        host_write_en   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [AW-1:0] w, input logic [AW-1:0] x,
                        input logic [AW-1:0] o, input logic [TGW-1:0] t);
        cmd_valid    = 1'b1;
        cmd_addr_w   = w;
        cmd_addr_x   = x;
        cmd_addr_out = o;
        cmd_tag      = t;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        host_req_addr = AW'($urandom);
        host_req_data = MW'($urandom);
        host_read_en  = 1'b1;
        #1;
        n_cmp++;
        if ({sa_start, busy, cpl_valid, cpl_error, cpl_tag, queue_count,
             sa_base_addr_w, sa_base_addr_x, sa_base_addr_out} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got start=%b busy=%b cv=%b ce=%b ct=%h qc=%0d w=%h x=%h o=%h want all 0",
                     sa_start, busy, cpl_valid, cpl_error, cpl_tag, queue_count,
                     sa_base_addr_w, sa_base_addr_x, sa_base_addr_out);
        end
        n_cmp++;
        if ({host_gnt, mem_read_en, mem_write_en, mem_req_addr, mem_req_data} !==
            {1'b1, 1'b1, 1'b0, host_req_addr, host_req_data}) begin
            n_err++;
            $display("FAIL reset_host_path: got gnt=%b rd=%b wr=%b a=%h d=%h want gnt=1 rd=1 wr=0 a=%h d=%h",
                     host_gnt, mem_read_en, mem_write_en, mem_req_addr, mem_req_data,
                     host_req_addr, host_req_data);
        end
        tick();
        rst_n = 1'b1;
        host_read_en = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_job();
        int starts = 0;
        int early  = 0;
        do_reset();
        cpl_ready = 1'b1;
        push(13'h100, 13'h200, 13'h300, 4'd5);
        tick();
        n_cmp++;
        if (sa_start !== 1'b1) begin
            n_err++;
            $display("FAIL single_start_latency: sa_start=%b at t+2 want 1", sa_start);
        end
        n_cmp++;
        if ({sa_base_addr_w, sa_base_addr_x, sa_base_addr_out} !==
            {13'h100, 13'h200, 13'h300}) begin
            n_err++;
            $display("FAIL single_addrs: got %h %h %h want 100 200 300",
                     sa_base_addr_w, sa_base_addr_x, sa_base_addr_out);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sa_start) starts++;
            if (cpl_valid) early++;
        end
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        n_cmp++;
        if (starts != 0 || early != 0) begin
            n_err++;
            $display("FAIL single_quiet_run: extra starts=%0d early cpl=%0d want 0 0", starts, early);
        end
        n_cmp++;
        if ({cpl_valid, cpl_tag, cpl_error} !== {1'b1, 4'd5, 1'b0}) begin
            n_err++;
            $display("FAIL single_cpl: got v=%b tag=%0d err=%b want v=1 tag=5 err=0",
                     cpl_valid, cpl_tag, cpl_error);
        end
        tick();
        n_cmp++;
        if ({busy, cpl_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle_after: got busy=%b cv=%b want 0 0", busy, cpl_valid);
        end
    endtask

    task automatic test_queue_full();
        logic [AW-1:0] exp_w [5];
        int st  = 0;
        int cp  = 0;
        int dly = -1;
        do_reset();
        cpl_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = AW'($urandom);
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL full_ready_push%0d: got %b want 1", i, cmd_ready);
            end
            push(exp_w[i], AW'($urandom), AW'($urandom), TGW'(i));
            if (sa_start) begin
                n_cmp++;
                if (sa_base_addr_w !== exp_w[st]) begin
                    n_err++;
                    $display("FAIL full_start_addr%0d: got %h want %h", st, sa_base_addr_w, exp_w[st]);
                end
                st++;
            end
        end
        n_cmp++;
        if ({cmd_ready, queue_count} !== {1'b0, QCW'(4)}) begin
            n_err++;
            $display("FAIL full_state: got ready=%b count=%0d want ready=0 count=4",
                     cmd_ready, queue_count);
        end
        cmd_valid = 1'b1;
        cmd_tag   = 4'd7;
        tick();
        tick();
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (queue_count !== QCW'(4)) begin
            n_err++;
            $display("FAIL full_refuse: count=%0d want 4", queue_count);
        end
        dly = 3;
        for (int c = 0; c < 2000 && cp < 5; c++) begin
            sa_done = (dly == 0);
            if (dly >= 0) dly--;
            tick();
            sa_done = 1'b0;
            if (sa_start) begin
                n_cmp++;
                if (st >= 5 || sa_base_addr_w !== exp_w[st % 5]) begin
                    n_err++;
                    $display("FAIL full_start_addr%0d: got %h want %h", st, sa_base_addr_w, exp_w[st % 5]);
                end
                st++;
                dly = $urandom_range(2, 10);
            end
            if (cpl_valid) begin
                n_cmp++;
                if ({cpl_tag, cpl_error} !== {TGW'(cp), 1'b0}) begin
                    n_err++;
                    $display("FAIL full_cpl%0d: got tag=%0d err=%b want tag=%0d err=0",
                             cp, cpl_tag, cpl_error, cp);
                end
                cp++;
            end
        end
        n_cmp++;
        if (cp != 5 || st != 5) begin
            n_err++;
            $display("FAIL full_totals: got cpl=%0d starts=%0d want 5 5", cp, st);
        end
    endtask

    task automatic test_host_drain();
        int n = 0;
        do_reset();
        cpl_ready     = 1'b1;
        host_read_en  = 1'b1;
        host_req_addr = AW'($urandom);
        cmd_valid     = 1'b1;
        cmd_addr_w    = AW'($urandom);
        cmd_tag       = 4'd9;
        #1;
        n_cmp++;
        if ({mem_read_en, mem_req_addr} !== {1'b1, host_req_addr}) begin
            n_err++;
            $display("FAIL drain_fwd: got rd=%b a=%h want rd=1 a=%h", mem_read_en, mem_req_addr, host_req_addr);
        end
        tick();
        cmd_valid     = 1'b0;
        host_req_addr = AW'($urandom);
        #1;
        n_cmp++;
        if ({host_gnt, mem_read_en} !== 2'b00) begin
            n_err++;
            $display("FAIL drain_block: got gnt=%b rd=%b want 0 0", host_gnt, mem_read_en);
        end
        host_read_en = 1'b0;
        n = 1;
        while (!sa_start && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sa_start !== 1'b1 || n < ML + 1) begin
            n_err++;
            $display("FAIL drain_start: start=%b at t+%0d want 1 at >= t+%0d", sa_start, n, ML + 1);
        end
        tick();
        host_read_en    = 1'b1;
        host_write_en   = 1'b1;
        sa_mem_read_en  = 1'b0;
        sa_mem_write_en = 1'b1;
        sa_mem_req_addr = AW'($urandom);
        #1;
        n_cmp++;
        if ({host_gnt, mem_read_en, mem_write_en, mem_req_addr} !==
            {1'b0, 1'b0, 1'b1, sa_mem_req_addr}) begin
            n_err++;
            $display("FAIL drain_run_mux: got gnt=%b rd=%b wr=%b a=%h want 0 0 1 %h",
                     host_gnt, mem_read_en, mem_write_en, mem_req_addr, sa_mem_req_addr);
        end
        idle_inputs();
        cpl_ready = 1'b1;
        sa_done   = 1'b1;
        tick();
        sa_done = 1'b0;
        n_cmp++;
        if ({cpl_valid, cpl_tag} !== {1'b1, 4'd9}) begin
            n_err++;
            $display("FAIL drain_cpl: got v=%b tag=%0d want 1 9", cpl_valid, cpl_tag);
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        do_reset();
        push(AW'($urandom), AW'($urandom), AW'($urandom), 4'd3);
        tick();
        n_cmp++;
        if (sa_start !== 1'b1) begin
            n_err++;
            $display("FAIL to_start: got %b want 1", sa_start);
        end
        for (int k = 0; k < TO; k++) begin
            tick();
            if (cpl_valid) early++;
        end
        tick();
        n_cmp++;
        if (early != 0 || {cpl_valid, cpl_tag, cpl_error} !== {1'b1, 4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL to_cpl: early=%0d v=%b tag=%0d err=%b want 0 1 3 1",
                     early, cpl_valid, cpl_tag, cpl_error);
        end
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        n_cmp++;
        if ({cpl_valid, cpl_error} !== 2'b11) begin
            n_err++;
            $display("FAIL to_late_done: got v=%b err=%b want 1 1", cpl_valid, cpl_error);
        end
        cpl_ready = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_done_at_timeout();
        int early = 0;
        do_reset();
        push(AW'($urandom), AW'($urandom), AW'($urandom), 4'd6);
        tick();
        for (int k = 0; k < TO; k++) begin
            tick();
            if (cpl_valid) early++;
        end
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        n_cmp++;
        if (early != 0 || {cpl_valid, cpl_tag, cpl_error} !== {1'b1, 4'd6, 1'b0}) begin
            n_err++;
            $display("FAIL done_vs_timeout: early=%0d v=%b tag=%0d err=%b want 0 1 6 0",
                     early, cpl_valid, cpl_tag, cpl_error);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] bw;
        do_reset();
        cpl_ready = 1'b1;
        bw = AW'($urandom);
        push(AW'($urandom), AW'($urandom), AW'($urandom), 4'd1);
        push(bw, AW'($urandom), AW'($urandom), 4'd2);
        for (int k = 0; k < 5; k++) tick();
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        n_cmp++;
        if ({cpl_valid, cpl_tag} !== {1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL b2b_cpl: got v=%b tag=%0d want 1 1", cpl_valid, cpl_tag);
        end
        tick();
        n_cmp++;
        if (sa_start !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_start_d2: got %b want 0", sa_start);
        end
        tick();
        n_cmp++;
        if ({sa_start, sa_base_addr_w} !== {1'b1, bw}) begin
            n_err++;
            $display("FAIL b2b_start_d3: got start=%b w=%h want 1 %h", sa_start, sa_base_addr_w, bw);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] bw;
        int bad = 0;
        do_reset();
        bw = AW'($urandom);
        push(AW'($urandom), AW'($urandom), AW'($urandom), 4'd10);
        push(bw, AW'($urandom), AW'($urandom), 4'd11);
        for (int k = 0; k < 4; k++) tick();
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ({cpl_valid, cpl_tag, cpl_error, sa_start} !== {1'b1, 4'd10, 1'b0, 1'b0}) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_stable: %0d unstable cycles, now v=%b tag=%0d err=%b start=%b want 1 10 0 0",
                     bad, cpl_valid, cpl_tag, cpl_error, sa_start);
        end
        cpl_ready = 1'b1;
        tick();
        n_cmp++;
        if ({cpl_valid, sa_start} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_release: got v=%b start=%b want 0 0", cpl_valid, sa_start);
        end
        tick();
        n_cmp++;
        if ({sa_start, sa_base_addr_w} !== {1'b1, bw}) begin
            n_err++;
            $display("FAIL bp_next_start: got start=%b w=%h want 1 %h", sa_start, sa_base_addr_w, bw);
        end
    endtask

    task automatic test_random();
        job_t pend[$];
        job_t cur;
        job_t nj;
        int mcnt = 0;
        int dly = -1;
        int last_fwd = -100;
        int npush = 0;
        int ncpl = 0;
        bit active = 0;
        bit exp_gnt;
        bit started;
        logic [AW+MW+1:0] exp_mem;
        do_reset();
        cur = '{w: '0, x: '0, o: '0, tag: '0};
        for (int c = 0; c < 1200; c++) begin
            started = sa_start;
            if (sa_start) begin
                n_cmp++;
                if (active || pend.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_start_legal: active=%b pending=%0d want 0 >0", active, pend.size());
                end else begin
                    cur = pend.pop_front();
                    n_cmp++;
                    if ({sa_base_addr_w, sa_base_addr_x, sa_base_addr_out} !== {cur.w, cur.x, cur.o}) begin
                        n_err++;
                        $display("FAIL rnd_start_addr: got %h %h %h want %h %h %h",
                                 sa_base_addr_w, sa_base_addr_x, sa_base_addr_out, cur.w, cur.x, cur.o);
                    end
                end
                n_cmp++;
                if (cyc - last_fwd <= ML) begin
                    n_err++;
                    $display("FAIL rnd_drain: start %0d cycles after host access want > %0d", cyc - last_fwd, ML);
                end
                active = 1;
                dly = $urandom_range(1, 30);
            end
            if (cpl_valid) begin
                n_cmp++;
                if (!active || {cpl_tag, cpl_error} !== {cur.tag, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_cpl: active=%b tag=%0d err=%b want 1 %0d 0", active, cpl_tag, cpl_error, cur.tag);
                end
            end
            cmd_valid       = (c < 900) && ($urandom_range(0, 2) == 0);
            nj.w            = AW'($urandom);
            nj.x            = AW'($urandom);
            nj.o            = AW'($urandom);
            nj.tag          = TGW'($urandom);
            cmd_addr_w      = nj.w;
            cmd_addr_x      = nj.x;
            cmd_addr_out    = nj.o;
            cmd_tag         = nj.tag;
            cpl_ready       = ($urandom_range(0, 3) != 0);
            sa_done         = (dly == 0) || (!active && $urandom_range(0, 7) == 0);
            if (dly >= 0) dly--;
            host_read_en    = ($urandom_range(0, 3) == 0);
            host_write_en   = ($urandom_range(0, 5) == 0);
            host_req_addr   = AW'($urandom);
            host_req_data   = MW'($urandom);
            sa_mem_read_en  = $urandom_range(0, 1) == 1;
            sa_mem_write_en = $urandom_range(0, 1) == 1;
            sa_mem_req_addr = AW'($urandom);
            sa_mem_req_data = MW'($urandom);
            #1;
            exp_gnt = !active && mcnt == 0;
            n_cmp++;
            if ({host_gnt, busy, queue_count, cmd_ready} !==
                {exp_gnt, active, QCW'(mcnt), mcnt < QD}) begin
                n_err++;
                $display("FAIL rnd_status: got gnt=%b busy=%b qc=%0d rdy=%b want %b %b %0d %b",
                         host_gnt, busy, queue_count, cmd_ready, exp_gnt, active, mcnt, mcnt < QD);
            end
            if (active)
                exp_mem = {sa_mem_req_addr, sa_mem_req_data, sa_mem_read_en, sa_mem_write_en};
            else if (exp_gnt)
                exp_mem = {host_req_addr, host_req_data, host_read_en, host_write_en};
            else
                exp_mem = '0;
            n_cmp++;
            if ({mem_req_addr, mem_req_data, mem_read_en, mem_write_en} !== exp_mem) begin
                n_err++;
                $display("FAIL rnd_mem_mux: got %h want %h",
                         {mem_req_addr, mem_req_data, mem_read_en, mem_write_en}, exp_mem);
            end
            if (exp_gnt && (host_read_en || host_write_en)) last_fwd = cyc;
            if (cmd_valid && mcnt < QD) begin
                pend.push_back(nj);
                mcnt++;
                npush++;
            end
            if (started) mcnt--;
            if (cpl_valid && cpl_ready) begin
                active = 0;
                ncpl++;
            end
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (ncpl != npush || pend.size() != 0 || active) begin
            n_err++;
            $display("FAIL rnd_totals: cpl=%0d pushed=%0d pending=%0d active=%b want equal 0 0",
                     ncpl, npush, pend.size(), active);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_cpl = 0;
        int seen_start = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(AW'($urandom), AW'($urandom), AW'($urandom), TGW'(i));
        end
        n_cmp++;
        if ({busy, queue_count} !== {1'b1, QCW'(3)}) begin
            n_err++;
            $display("FAIL rmr_setup: got busy=%b qc=%0d want 1 3", busy, queue_count);
        end
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sa_start, busy, cpl_valid, cpl_error, cpl_tag, queue_count,
             sa_base_addr_w, sa_base_addr_x, sa_base_addr_out, host_gnt} !== {'0, 1'b1}) begin
            n_err++;
            $display("FAIL rmr_async: start=%b busy=%b cv=%b qc=%0d w=%h gnt=%b want 0 0 0 0 0 1",
                     sa_start, busy, cpl_valid, queue_count, sa_base_addr_w, host_gnt);
        end
        tick();
        rst_n = 1'b1;
        cpl_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            sa_done = (k % 7 == 3);
            tick();
            if (cpl_valid) seen_cpl++;
            if (sa_start) seen_start++;
        end
        sa_done = 1'b0;
        n_cmp++;
        if (seen_cpl != 0 || seen_start != 0 || queue_count !== '0) begin
            n_err++;
            $display("FAIL rmr_after: cpl=%0d start=%0d qc=%0d want 0 0 0",
                     seen_cpl, seen_start, queue_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_job();
        test_queue_full();
        test_host_drain();
        test_timeout();
        test_done_at_timeout();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
